// File: rtl/core_pkg.sv
// Shared types and constants for the decode-stage hazard/forwarding logic.
package core_pkg;

    // Tag register index width. Wide enough for any ADDR_SIZE up to 8.
    // Narrower indices are zero-extended into it.
    localparam int TAG_RD_W = 8;

    // Bit positions inside each 2-bit bypass bus: {fwd_ra, fwd_rb}.
    localparam int BP_RA = 1;
    localparam int BP_RB = 0;

    // x0 is hardwired to zero, so it never forwards and never causes a stall.
    localparam logic [TAG_RD_W-1:0] REG_ZERO = '0;

    // Destination tag carried by each of the EX, MEM and WB stages.
    typedef struct packed {
        logic                valid;
        logic [TAG_RD_W-1:0] rd;
        logic                wr;    // writes rd (ALU/memory write or link write)
        logic                ld;    // load: data is not available until MEM
        logic                link;  // JALX link write: data is not available until WB
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;

    // True when the stage will deliver a new value for register r.
    function automatic logic tag_produces(input stage_tag_t t,
                                          input logic [TAG_RD_W-1:0] r);
        return t.valid & t.wr & (t.rd == r) & (r != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_select.sv
// Per-operand bypass priority encoder: picks the youngest producer of one
// source register and reports whether its data can be forwarded or must stall.
module fwd_select
    import core_pkg::*;
(
    input  logic [TAG_RD_W-1:0] src,
    input  logic                src_used,
    input  stage_tag_t          ex_tag,
    input  stage_tag_t          mem_tag,
    input  stage_tag_t          wb_tag,
    input  logic                mul_busy,
    output logic                hit_ex,
    output logic                hit_mem,
    output logic                hit_wb,
    output logic                stall
);

    logic prod_ex;
    logic prod_mem;
    logic prod_wb;

    // Load/link flags of the older stages have no effect on the choice:
    // by MEM a load has its data, and by WB a link value is on the write port.
    logic unused_tag_bits;
    assign unused_tag_bits = ^{mem_tag.ld, wb_tag.ld, wb_tag.link};

    assign prod_ex  = tag_produces(ex_tag,  src);
    assign prod_mem = tag_produces(mem_tag, src);
    assign prod_wb  = tag_produces(wb_tag,  src);

    // EX > MEM > WB; a younger producer that cannot forward yet stalls rather
    // than falling back to a stale older value.
    always_comb begin
        hit_ex  = 1'b0;
        hit_mem = 1'b0;
        hit_wb  = 1'b0;
        stall   = 1'b0;
        if (src_used) begin
            if (prod_ex) begin
                if (ex_tag.ld | ex_tag.link | mul_busy) begin
                    stall = 1'b1;
                end else begin
                    hit_ex = 1'b1;
                end
            end else if (prod_mem) begin
                if (mem_tag.link) begin
                    stall = 1'b1;
                end else begin
                    hit_mem = 1'b1;
                end
            end else if (prod_wb) begin
                hit_wb = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-stage hazard and forwarding controller for the 5-stage core.
// Tracks EX/MEM/WB destination tags, drives the register-file bypass selects
// and stalls decode on load-use, link-use and multi-cycle multiply hazards.
module hazard_fwd_unit
    import core_pkg::*;
#(
    parameter int ADDR_SIZE = 5,
    parameter int MUL_LAT   = 3
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 D_valid,
    input  logic [ADDR_SIZE-1:0] D_ra,
    input  logic [ADDR_SIZE-1:0] D_rb,
    input  logic                 D_use_ra,
    input  logic                 D_use_rb,
    input  logic [ADDR_SIZE-1:0] D_rd,
    input  logic                 D_we,
    input  logic                 D_ld,
    input  logic                 D_link_we,
    input  logic                 D_mul,
    input  logic                 flush_D,
    output logic [1:0]           EX_D_bp,
    output logic [1:0]           MEM_D_bp,
    output logic [1:0]           WB_D_bp,
    output logic                 stall_D,
    output logic                 mul_busy
);

    // Counter only needs to hold MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    stage_tag_t       ex_tag_p0;
    stage_tag_t       mem_tag_p1;
    stage_tag_t       wb_tag_p2;
    stage_tag_t       ex_nxt;
    stage_tag_t       mem_nxt;
    stage_tag_t       wb_nxt;
    stage_tag_t       d_tag;
    logic [CNT_W-1:0] mul_cnt;
    logic [CNT_W-1:0] mul_cnt_nxt;
    logic             d_accept;
    logic             ra_ex, ra_mem, ra_wb, ra_stall;
    logic             rb_ex, rb_mem, rb_wb, rb_stall;

    assign mul_busy = (mul_cnt != '0);

    // Tag the decode instruction would carry into EX.
    assign d_tag = '{valid: 1'b1,
                     rd:    TAG_RD_W'(D_rd),
                     wr:    D_we | D_link_we,
                     ld:    D_ld,
                     link:  D_link_we};

    fwd_select u_fwd_ra (
        .src      (TAG_RD_W'(D_ra)),
        .src_used (D_valid & D_use_ra),
        .ex_tag   (ex_tag_p0),
        .mem_tag  (mem_tag_p1),
        .wb_tag   (wb_tag_p2),
        .mul_busy (mul_busy),
        .hit_ex   (ra_ex),
        .hit_mem  (ra_mem),
        .hit_wb   (ra_wb),
        .stall    (ra_stall)
    );

    fwd_select u_fwd_rb (
        .src      (TAG_RD_W'(D_rb)),
        .src_used (D_valid & D_use_rb),
        .ex_tag   (ex_tag_p0),
        .mem_tag  (mem_tag_p1),
        .wb_tag   (wb_tag_p2),
        .mul_busy (mul_busy),
        .hit_ex   (rb_ex),
        .hit_mem  (rb_mem),
        .hit_wb   (rb_wb),
        .stall    (rb_stall)
    );

    // A flushed decode instruction is dead, so it can neither stall nor be accepted.
    assign stall_D  = D_valid & ~flush_D & (ra_stall | rb_stall | mul_busy);
    assign d_accept = D_valid & ~flush_D & ~stall_D;

    // Bypass selects; squashed while stalled so the bubble reads nothing.
    always_comb begin
        EX_D_bp  = 2'b00;
        MEM_D_bp = 2'b00;
        WB_D_bp  = 2'b00;
        if (!stall_D) begin
            EX_D_bp[BP_RA]  = ra_ex;
            EX_D_bp[BP_RB]  = rb_ex;
            MEM_D_bp[BP_RA] = ra_mem;
            MEM_D_bp[BP_RB] = rb_mem;
            WB_D_bp[BP_RA]  = ra_wb;
            WB_D_bp[BP_RB]  = rb_wb;
        end
    end

    // Tag advance: a busy multiply holds EX and drains MEM/WB behind it;
    // otherwise the pipe shifts and EX takes the decode tag or a bubble.
    always_comb begin
        ex_nxt  = ex_tag_p0;
        mem_nxt = mem_tag_p1;
        wb_nxt  = wb_tag_p2;
        if (mul_busy) begin
            mem_nxt = TAG_BUBBLE;
            wb_nxt  = mem_tag_p1;
        end else begin
            wb_nxt  = mem_tag_p1;
            mem_nxt = ex_tag_p0;
            ex_nxt  = d_accept ? d_tag : TAG_BUBBLE;
        end
    end

    // Multiply occupancy: load on acceptance, then count down to idle.
    always_comb begin
        mul_cnt_nxt = mul_cnt;
        if (d_accept && D_mul) begin
            mul_cnt_nxt = MUL_LOAD;
        end else if (mul_busy) begin
            mul_cnt_nxt = mul_cnt - CNT_ONE;
        end
    end

    // ---- EX / MEM / WB tag registers and multiply counter ----
    // Reset clears all tags and abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_tag_p0  <= TAG_BUBBLE;
            mem_tag_p1 <= TAG_BUBBLE;
            wb_tag_p2  <= TAG_BUBBLE;
            mul_cnt    <= '0;
        end else begin
            ex_tag_p0  <= ex_nxt;
            mem_tag_p1 <= mem_nxt;
            wb_tag_p2  <= wb_nxt;
            mul_cnt    <= mul_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed vector table, hand-written reset
// sequences and randomized traffic against an instruction-level model.
module tb_hazard_fwd_unit;

    localparam int ADDR_SIZE = 5;
    localparam int MUL_LAT   = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 d_valid;
    logic [ADDR_SIZE-1:0] d_ra, d_rb, d_rd;
    logic                 d_use_ra, d_use_rb, d_we, d_ld, d_link, d_mul, d_flush;
    logic [1:0]           ex_bp, mem_bp, wb_bp;
    logic                 stall, busy;

    int total = 0;
    int bad   = 0;

    hazard_fwd_unit #(.ADDR_SIZE(ADDR_SIZE), .MUL_LAT(MUL_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D_valid   (d_valid),
        .D_ra      (d_ra),
        .D_rb      (d_rb),
        .D_use_ra  (d_use_ra),
        .D_use_rb  (d_use_rb),
        .D_rd      (d_rd),
        .D_we      (d_we),
        .D_ld      (d_ld),
        .D_link_we (d_link),
        .D_mul     (d_mul),
        .flush_D   (d_flush),
        .EX_D_bp   (ex_bp),
        .MEM_D_bp  (mem_bp),
        .WB_D_bp   (wb_bp),
        .stall_D   (stall),
        .mul_busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [4:0] ra; logic ua; logic [4:0] rb; logic ub;
        logic [4:0] rd; logic we; logic ld; logic lk; logic mul; logic fl;
        logic [1:0] e_ex; logic [1:0] e_mem; logic [1:0] e_wb; logic e_st; logic e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int v, int ra, int ua, int rb, int ub, int rd, int we,
                                int ld, int lk, int mul, int fl,
                                int eex, int emem, int ewb, int est, int ebusy);
        vec_t r;
        r.v = 1'(v); r.ra = 5'(ra); r.ua = 1'(ua); r.rb = 5'(rb); r.ub = 1'(ub);
        r.rd = 5'(rd); r.we = 1'(we); r.ld = 1'(ld); r.lk = 1'(lk); r.mul = 1'(mul);
        r.fl = 1'(fl); r.e_ex = 2'(eex); r.e_mem = 2'(emem); r.e_wb = 2'(ewb);
        r.e_st = 1'(est); r.e_busy = 1'(ebusy);
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0,0, 0,0, 0,0,0,0,0,0, 0,0,0,0,0);
    endfunction

    task automatic drive(input vec_t x);
        d_valid = x.v; d_ra = x.ra; d_use_ra = x.ua; d_rb = x.rb; d_use_rb = x.ub;
        d_rd = x.rd; d_we = x.we; d_ld = x.ld; d_link = x.lk; d_mul = x.mul; d_flush = x.fl;
    endtask

    task automatic chk(input string nm, input int idx, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%b want=%b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int idx, input logic [1:0] eex, input logic [1:0] emem,
                           input logic [1:0] ewb, input logic est, input logic ebusy);
        chk({tag, ".EX_D_bp"},  idx, ex_bp,  eex);
        chk({tag, ".MEM_D_bp"}, idx, mem_bp, emem);
        chk({tag, ".WB_D_bp"},  idx, wb_bp,  ewb);
        chk({tag, ".stall_D"},  idx, {1'b0, stall}, {1'b0, est});
        chk({tag, ".mul_busy"}, idx, {1'b0, busy},  {1'b0, ebusy});
    endtask

    // ---------------- reference model: instructions in flight ----------------
    typedef struct { bit valid; int rd; bit wr; bit ld; bit link; } mslot_t;
    mslot_t m_st[3];     // index 0 = EX, 1 = MEM, 2 = WB
    int     m_rem;       // multiply cycles still owed after acceptance

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_st[i] = '{0, 0, 0, 0, 0};
        m_rem = 0;
    endtask

    function automatic int youngest_writer(int r);
        if (r == 0) return -1;
        for (int s = 0; s < 3; s++)
            if (m_st[s].valid && m_st[s].wr && m_st[s].rd == r) return s;
        return -1;
    endfunction

    task automatic model_eval(output logic [1:0] e, output logic [1:0] m, output logic [1:0] w,
                              output logic st, output logic bsy);
        bit hz = 0;
        e = 0; m = 0; w = 0;
        bsy = (m_rem > 0);
        for (int op = 0; op < 2; op++) begin
            int r   = (op == 0) ? int'(d_ra) : int'(d_rb);
            bit use_it = d_valid && ((op == 0) ? d_use_ra : d_use_rb);
            int pos = (op == 0) ? 1 : 0;
            if (use_it) begin
                int s = youngest_writer(r);
                if (s == 0) begin
                    if (m_st[0].ld || m_st[0].link || bsy) hz = 1; else e[pos] = 1'b1;
                end else if (s == 1) begin
                    if (m_st[1].link) hz = 1; else m[pos] = 1'b1;
                end else if (s == 2) begin
                    w[pos] = 1'b1;
                end
            end
        end
        st = d_valid && !d_flush && (hz || bsy);
        if (st) begin e = 0; m = 0; w = 0; end
    endtask

    task automatic model_step(input logic st);
        bit bsy = (m_rem > 0);
        bit acc = d_valid && !d_flush && !st;
        mslot_t nd = '{acc, int'(d_rd), d_we || d_link, d_ld, d_link};
        mslot_t bub = '{0, 0, 0, 0, 0};
        m_st[2] = m_st[1];
        if (bsy) begin
            m_st[1] = bub;
        end else begin
            m_st[1] = m_st[0];
            m_st[0] = acc ? nd : bub;
        end
        if (acc && d_mul) m_rem = MUL_LAT - 1;
        else if (m_rem > 0) m_rem--;
    endtask

    initial begin
        logic [1:0] pe, pm, pw;
        logic ps, pb;

        // Directed sequences, applied back to back; state carries between rows.
        // mk(v, ra,ua, rb,ub, rd,we,ld,lk,mul,fl, ex,mem,wb,stall,busy)
        vecs.push_back(mk(1, 1,1, 2,1, 3,1,0,0,0,0, 0,0,0,0,0));  // add r3
        vecs.push_back(mk(1, 3,1, 3,1, 8,1,0,0,0,0, 3,0,0,0,0));  // reads r3 twice
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 5,1,1,0,0,0, 0,0,0,0,0));  // lw r5
        vecs.push_back(mk(1, 0,1, 5,1, 9,1,0,0,0,0, 0,0,0,1,0));  // load-use stall
        vecs.push_back(mk(1, 0,1, 5,1, 9,1,0,0,0,0, 0,1,0,0,0));  // then from MEM
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 7,1,0,0,0,0, 0,0,0,0,0));  // r7 (older)
        vecs.push_back(mk(1, 0,0, 0,0, 7,1,0,0,0,0, 0,0,0,0,0));  // r7 (younger)
        vecs.push_back(mk(1, 7,1, 0,0, 0,0,0,0,0,0, 2,0,0,0,0));  // EX wins over MEM
        vecs.push_back(mk(1, 7,1, 0,0, 0,0,0,0,0,0, 0,2,0,0,0));  // MEM wins over WB
        vecs.push_back(mk(1, 7,1, 0,0, 0,0,0,0,0,0, 0,0,2,0,0));  // WB only
        vecs.push_back(mk(1, 0,0, 0,0, 0,1,1,0,0,0, 0,0,0,0,0));  // load to x0
        vecs.push_back(mk(1, 0,1, 0,1, 0,0,0,0,0,0, 0,0,0,0,0));  // x0 never forwards/stalls
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 1,0,0,1,0,0, 0,0,0,0,0));  // jalx r1
        vecs.push_back(mk(1, 1,1, 0,0,10,1,0,0,0,0, 0,0,0,1,0));  // link in EX
        vecs.push_back(mk(1, 1,1, 0,0,10,1,0,0,0,0, 0,0,0,1,0));  // link in MEM
        vecs.push_back(mk(1, 1,1, 0,0,10,1,0,0,0,0, 0,0,2,0,0));  // link from WB
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 4,1,0,0,1,0, 0,0,0,0,0));  // mul r4
        vecs.push_back(mk(1, 4,1, 0,0,11,1,0,0,0,0, 0,0,0,1,1));
        vecs.push_back(mk(1, 4,1, 0,0,11,1,0,0,0,0, 0,0,0,1,1));
        vecs.push_back(mk(1, 4,1, 0,0,11,1,0,0,0,0, 2,0,0,0,0));  // mul result from EX
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 5,1,1,0,0,0, 0,0,0,0,0));  // lw r5
        vecs.push_back(mk(1, 0,0, 5,1, 5,1,0,0,0,1, 0,0,0,0,0));  // flushed, writes r5
        vecs.push_back(mk(1, 5,1, 0,0, 0,0,0,0,0,0, 0,2,0,0,0));  // bubble took EX
        repeat (3) vecs.push_back(idle());
        vecs.push_back(mk(1, 0,0, 0,0, 6,1,0,0,1,0, 0,0,0,0,0));  // mul r6
        vecs.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0,0, 0,0,0,0,1));  // busy, no decode -> no stall
        vecs.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0,0, 0,0,0,0,1));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0,0,0,0,0, 0,0,0,0,0));
        repeat (3) vecs.push_back(idle());

        // Reset state, with a decode instruction presenting operands.
        rst_n = 1'b0;
        drive(mk(1, 3,1, 3,1, 3,1,0,0,0,0, 0,0,0,0,0));
        #2;
        chk_all("reset", 0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk_all("vec", i, vecs[i].e_ex, vecs[i].e_mem, vecs[i].e_wb, vecs[i].e_st, vecs[i].e_busy);
        end

        // Reset in the middle of a multiply.
        @(negedge clk);
        drive(mk(1, 0,0, 0,0, 4,1,0,0,1,0, 0,0,0,0,0));
        @(negedge clk);
        drive(mk(1, 4,1, 4,1, 12,1,0,0,0,0, 0,0,0,0,0));
        #2;
        chk_all("pre_rst", 0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk_all("post_rst", 0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            d_valid  = ($urandom_range(0, 7) != 0);
            d_ra     = 5'($urandom_range(0, 5));
            d_rb     = 5'($urandom_range(0, 5));
            d_use_ra = 1'($urandom_range(0, 3) != 0);
            d_use_rb = 1'($urandom_range(0, 1));
            d_rd     = 5'($urandom_range(0, 5));
            d_ld     = ($urandom_range(0, 3) == 0);
            d_link   = ($urandom_range(0, 7) == 0);
            d_mul    = !d_ld && !d_link && ($urandom_range(0, 7) == 0);
            d_we     = !d_link && ($urandom_range(0, 4) != 0);
            d_flush  = ($urandom_range(0, 9) == 0);
            #2;
            model_eval(pe, pm, pw, ps, pb);
            chk_all("rand", c, pe, pm, pw, ps, pb);
            model_step(ps);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Decode-stage hazard and forwarding controller for the 5-stage core; it drives the register file's bypass selects.
- Tracks destination tags of instructions in EX, MEM and WB.
- Generates the per-operand bypass enables EX_D_bp / MEM_D_bp / WB_D_bp.
- Raises stall_D for load-use, link-use and multi-cycle multiply hazards.

Parameters:
- ADDR_SIZE, 5, register index width.
- MUL_LAT, 3, cycles a MUL occupies EX (>=1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- D_valid  in  1  instruction present in decode.
- D_ra  in  ADDR_SIZE  source A index.
- D_rb  in  ADDR_SIZE  source B index.
- D_use_ra  in  1  instruction reads ra.
- D_use_rb  in  1  instruction reads rb.
- D_rd  in  ADDR_SIZE  destination index.
- D_we  in  1  instruction writes rd through the ALU/memory path.
- D_ld  in  1  instruction is a load.
- D_link_we  in  1  JALX link write.
- D_mul  in  1  multiply.
- flush_D  in  1  kill the decode instruction (taken branch/jump).
- EX_D_bp  out  2  {fwd_ra, fwd_rb} from EX_alu_out.
- MEM_D_bp  out  2  {fwd_ra, fwd_rb} from MEM_data_mem.
- WB_D_bp  out  2  {fwd_ra, fwd_rb} from the WB write data.
- stall_D  out  1  hold fetch/decode and insert a bubble into EX.
- mul_busy  out  1  multiply still executing in EX.

Behaviour:
- Stage tag per stage (EX, MEM, WB) = {valid, rd, wr, ld, link}; wr = D_we|D_link_we.
- A tag "produces r" when valid & wr & rd==r & r!=0. Register x0 never forwards and never stalls.
- Per-operand source match applies only when D_valid & D_use_x. Priority is EX > MEM > WB, and at most one bit of each {ra}/{rb} column is set across the three buses.
- EX match:
  - ld=1 or link=1 or mul_busy=1 -> stall.
  - Otherwise set the EX bit.
- MEM match:
  - link=1 -> stall.
  - Otherwise set the MEM bit; load data is valid at MEM.
- WB match: set the WB bit. This covers link data.
- When stall_D=1, all bp outputs are forced to 2'b00.
- stall_D = D_valid & !flush_D & (any stall condition above, or mul_busy).
- Bypass outputs and stall_D are combinational from the current D inputs and the registered tags, so they are valid in the same cycle.

Tag advance (posedge clk):
- Normal: WB <= MEM, MEM <= EX, EX <= D tag. The D tag is valid only if D_valid & !flush_D & !stall_D.
- stall_D (no mul busy): WB <= MEM, MEM <= EX, EX <= bubble.
- mul_busy: EX held; MEM <= bubble; WB <= MEM.
- flush_D has priority over stall: the D instruction becomes a bubble.

Multiply counter:
- Accepting D_mul loads mul_cnt with MUL_LAT-1.
- mul_busy = (mul_cnt != 0). The counter decrements each cycle while nonzero.
- MUL_LAT=1 means no busy cycles.
- EX forwarding of a multiply result is allowed only when mul_busy=0.

Reset (async, rst_n low):
- All tag valid bits = 0 and mul_cnt = 0.
- Outputs settle to bp = 0, stall_D = 0, mul_busy = 0.
- Reset mid-multiply abandons the operation.

Decomposition:
- Shared package (core_pkg):
  - stage_tag_t struct {valid, rd, wr, ld, link}.
  - BP_RA=1 and BP_RB=0 bit positions.
  - REG_ZERO constant.
- One sub-module fwd_select: per-operand priority encoder taking (src, use, EX/MEM/WB tags, mul_busy) and returning {ex, mem, wb, stall}. It is instantiated twice, once for ra and once for rb.

Test Plan:
- ALU chain: add r3 in EX, next instruction uses ra=3, rb=3 -> EX_D_bp=2'b11, others 0, stall_D=0.
- Load-use: lw r5 in EX, next instruction uses rb=5 -> stall_D=1 for exactly 1 cycle, bp=0. On the following cycle MEM_D_bp=2'b01.
- Priority: r7 written by instructions in both EX and MEM, D reads ra=7 -> EX_D_bp=2'b10, MEM_D_bp=0. A separate case with ra=0 and a producer of x0 in EX -> all bp=0.
- JALX r1 followed by a reader of r1 -> stall 2 cycles (tag in EX, then MEM), then WB_D_bp[1]=1 with stall_D=0.
- MUL_LAT=3: mul r4 accepted -> mul_busy=1 and stall_D=1 for 2 cycles with bubbles into MEM. A dependent reader then gets EX_D_bp=2'b10.
- flush_D asserted together with a load-use stall condition -> stall_D=0 and a bubble enters EX. A separate case: rst_n pulsed low mid-multiply -> mul_busy=0 immediately and all bp=0.
